// File: rtl/m68k_bus_master.sv
// 68020-style async bus initiator: one request becomes 1..4 dynamically sized bus cycles.
// Zero-wait 32-bit read acks 5 edges after accept; each extra sub-cycle adds 4; REQ ignored while BUSY.
module m68k_bus_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        REQ_RW,
    input  logic [23:0] REQ_ADDR,
    input  logic [1:0]  REQ_SIZE,
    input  logic [31:0] REQ_WDATA,
    output logic        BUSY,
    output logic        ACK,
    output logic        ERR,
    output logic [31:0] RDATA,
    output logic [23:0] A,
    output logic [1:0]  SIZ,
    output logic        RW20,
    output logic        AS20,
    output logic        DS20,
    output logic [31:0] D_OUT,
    output logic        D_OE,
    input  logic [31:0] D_IN,
    input  logic [1:0]  DSACK,
    input  logic        BERR
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_STRB, S_WAIT, S_TERM, S_DONE
    } state_t;

    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [23:0] addr_q, addr_d;
    logic [2:0]  rem_q, rem_d;
    logic        rw_q, rw_d;
    logic        as_q, as_d;
    logic        ds_q, ds_d;
    logic        doe_q, doe_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [1:0]  off;
    logic [2:0]  avail;
    logic [2:0]  take;
    logic [5:0]  take_bits;
    logic [31:0] lane_sh;
    logic [31:0] rdata_acc;
    logic        req_bad;
    logic [2:0]  req_rem;
    logic [31:0] req_wbuf;

    // Byte offset within the responding port and how many bytes it can take from there.
    always_comb begin
        off   = 2'd0;
        avail = 3'd0;
        case (DSACK)
            2'b00: begin
                off   = addr_q[1:0];
                avail = 3'd4 - {1'b0, addr_q[1:0]};
            end
            2'b01: begin
                off   = {1'b0, addr_q[0]};
                avail = 3'd2 - {2'b00, addr_q[0]};
            end
            2'b10: avail = 3'd1;
            default: avail = 3'd0;
        endcase
        take      = (rem_q < avail) ? rem_q : avail;
        take_bits = {take, 3'b000};
        lane_sh   = D_IN << {off, 3'b000};
        rdata_acc = (rdata_q << take_bits) | (lane_sh >> (6'd32 - take_bits));
    end

    // Write operand is kept left-justified so the next byte to send is always D[31:24].
    always_comb begin
        req_bad  = 1'b0;
        req_rem  = 3'd4;
        req_wbuf = REQ_WDATA;
        case (REQ_SIZE)
            2'b01: begin
                req_rem  = 3'd1;
                req_wbuf = {REQ_WDATA[7:0], 24'h0};
            end
            2'b10: begin
                req_rem  = 3'd2;
                req_wbuf = {REQ_WDATA[15:0], 16'h0};
                req_bad  = REQ_ADDR[0];
            end
            2'b00: req_bad = |REQ_ADDR[1:0];
            default: begin
                req_rem  = 3'd0;
                req_wbuf = 32'h0;
                req_bad  = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        err_d   = err_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        rw_d    = rw_q;
        as_d    = as_q;
        ds_d    = ds_q;
        doe_d   = doe_q;
        wbuf_d  = wbuf_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (REQ) begin
                    busy_d  = 1'b1;
                    err_d   = req_bad;
                    rdata_d = 32'h0;
                    addr_d  = REQ_ADDR;
                    wbuf_d  = req_wbuf;
                    if (req_bad) begin
                        rem_d   = 3'd0;
                        state_d = S_DONE;
                    end else begin
                        rem_d   = req_rem;
                        rw_d    = REQ_RW;
                        doe_d   = ~REQ_RW;
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: state_d = S_STRB;
            S_STRB: begin
                as_d    = 1'b0;
                ds_d    = ~rw_q;
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                ds_d = 1'b0;
                if (!BERR) begin
                    err_d   = 1'b1;
                    state_d = S_TERM;
                end else if (DSACK != 2'b11) begin
                    if (rw_q) begin
                        rdata_d = rdata_acc;
                    end
                    wbuf_d  = wbuf_q << take_bits;
                    rem_d   = rem_q - take;
                    addr_d  = addr_q + {21'h0, take};
                    state_d = S_TERM;
                end else if (({1'b0, cnt_q} + 9'd1) >= TIMEOUT_LIM) begin
                    err_d   = 1'b1;
                    state_d = S_TERM;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (state_d == S_TERM) begin
                    as_d  = 1'b1;
                    ds_d  = 1'b1;
                    doe_d = 1'b0;
                end
            end
            S_TERM: begin
                if (DSACK == 2'b11 && BERR) begin
                    if (rem_q != 3'd0 && !err_q) begin
                        doe_d   = ~rw_q;
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                ack_d   = 1'b1;
                rw_d    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            addr_q  <= 24'h0;
            rem_q   <= 3'd0;
            rw_q    <= 1'b1;
            as_q    <= 1'b1;
            ds_q    <= 1'b1;
            doe_q   <= 1'b0;
            wbuf_q  <= 32'h0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            rw_q    <= rw_d;
            as_q    <= as_d;
            ds_q    <= ds_d;
            doe_q   <= doe_d;
            wbuf_q  <= wbuf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        case (rem_q)
            3'd1:    D_OUT = {4{wbuf_q[31:24]}};
            3'd2:    D_OUT = {2{wbuf_q[31:16]}};
            default: D_OUT = wbuf_q;
        endcase
    end

    assign BUSY  = busy_q;
    assign ACK   = ack_q;
    assign ERR   = err_q;
    assign RDATA = rdata_q;
    assign A     = addr_q;
    assign SIZ   = rem_q[1:0];
    assign RW20  = rw_q;
    assign AS20  = as_q;
    assign DS20  = ds_q;
    assign D_OE  = doe_q;

endmodule
